mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_pkg.sv | 36 +++
 rtl/mdu_div_step.sv | 27 ++
 rtl/mul_div_unit.sv | 173 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_div_unit_pkg : RV32M op codes, FSM states and operand-sign helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_OP_MUL    = 3'd0,
    MDU_OP_MULH   = 3'd1,
    MDU_OP_MULHSU = 3'd2,
    MDU_OP_MULHU  = 3'd3,
    MDU_OP_DIV    = 3'd4,
    MDU_OP_DIVU   = 3'd5,
    MDU_OP_REM    = 3'd6,
    MDU_OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_CALC = 2'd1,
    MDU_ST_FIN  = 2'd2,
    MDU_ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MDU_OP_MULH) || (op == MDU_OP_DIV) || (op == MDU_OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_div_step : one combinational restoring-divide iteration
// Revision: 1.0
// ---------------------------------------------------------------------------
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_dividend_bit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_q_bit
);

  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;

  // The shifted remainder needs one extra bit; the restored/subtracted
  // result always fits back into XLEN bits because it stays below the divisor.
  assign w_shift = {i_rem, i_dividend_bit};
  assign o_q_bit = (w_shift >= {1'b0, i_divisor});
  assign w_diff  = w_shift[XLEN-1:0] - i_divisor;
  assign o_rem   = o_q_bit ? w_diff : w_shift[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_div_unit : iterative radix-2 RV32M multiply/divide, start/done handshake
// Option macro: MDU_FAST_MUL_EN (single-cycle combinational multiplies)
// Revision: 1.0
// ---------------------------------------------------------------------------
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        r_state, w_state_nxt;
  logic [2:0]        r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_hi, r_lo, r_opnd;
  logic              r_neg, r_special;
  logic [XLEN-1:0]   r_spec_val, r_result;

  logic              w_is_div, w_is_rem, w_a_neg, w_b_neg, w_neg, w_signed_ovf;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_val;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN-1:0]   w_div_rem;
  logic              w_q_bit;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quot_s, w_rem_s, w_final;

  // ---------------- accept-time decode ----------------
  assign w_is_div = op[2];
  assign w_is_rem = op[2] & op[1];
  assign w_a_neg  = op_a_signed(op) & srcA[XLEN-1];
  assign w_b_neg  = op_b_signed(op) & srcB[XLEN-1];
  assign w_mag_a  = w_a_neg ? (-srcA) : srcA;
  assign w_mag_b  = w_b_neg ? (-srcB) : srcB;
  // Remainder takes the dividend's sign; products and quotients the XOR.
  assign w_neg    = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_signed_ovf = ((op == MDU_OP_DIV) || (op == MDU_OP_REM)) &&
                        (srcA == c_int_min) && (srcB == '1);

`ifdef MDU_FAST_MUL_EN
  logic signed [XLEN:0]     w_fa, w_fb;
  logic signed [2*XLEN-1:0] w_fast_prod;
  assign w_fa        = {op_a_signed(op) & srcA[XLEN-1], srcA};
  assign w_fb        = {op_b_signed(op) & srcB[XLEN-1], srcB};
  assign w_fast_prod = w_fa * w_fb;
`endif

  always_comb begin
    w_special  = 1'b0;
    w_spec_val = '0;
    if (w_is_div && (srcB == '0)) begin
      w_special  = 1'b1;
      w_spec_val = w_is_rem ? srcA : '1;
    end else if (w_signed_ovf) begin
      w_special  = 1'b1;
      w_spec_val = w_is_rem ? '0 : c_int_min;
    end
`ifdef MDU_FAST_MUL_EN
    else if (!w_is_div) begin
      w_special  = 1'b1;
      w_spec_val = (op == MDU_OP_MUL) ? w_fast_prod[XLEN-1:0]
                                      : w_fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // ---------------- iteration datapath ----------------
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem          (r_hi),
    .i_dividend_bit (r_lo[XLEN-1]),
    .i_divisor      (r_opnd),
    .o_rem          (w_div_rem),
    .o_q_bit        (w_q_bit)
  );

  // ---------------- sign fixup and output select ----------------
  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? (-w_prod) : w_prod;
  assign w_quot_s = r_neg ? (-r_lo) : r_lo;
  assign w_rem_s  = r_neg ? (-r_hi) : r_hi;

  always_comb begin
    w_final = '0;
    case (r_op)
      MDU_OP_MUL:                           w_final = w_prod_s[XLEN-1:0];
      MDU_OP_MULH, MDU_OP_MULHSU,
      MDU_OP_MULHU:                         w_final = w_prod_s[2*XLEN-1:XLEN];
      MDU_OP_DIV, MDU_OP_DIVU:              w_final = w_quot_s;
      default:                              w_final = w_rem_s;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= MDU_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MDU_ST_IDLE: if (start) w_state_nxt = w_special ? MDU_ST_FIN : MDU_ST_CALC;
      MDU_ST_CALC: if (r_cnt == CNT_W'(XLEN-1)) w_state_nxt = MDU_ST_FIN;
      MDU_ST_FIN:  w_state_nxt = MDU_ST_DONE;
      MDU_ST_DONE: w_state_nxt = MDU_ST_IDLE;
      default:     w_state_nxt = MDU_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_neg      <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= '0;
      r_result   <= '0;
    end else begin
      case (r_state)
        MDU_ST_IDLE: if (start) begin
          r_op       <= op;
          r_cnt      <= '0;
          r_neg      <= w_neg;
          r_special  <= w_special;
          r_spec_val <= w_spec_val;
          r_hi       <= '0;
          // Divide: dividend shifts out of r_lo, divisor in r_opnd.
          // Multiply: multiplier shifts out of r_lo, multiplicand in r_opnd.
          r_lo       <= w_is_div ? w_mag_a : w_mag_b;
          r_opnd     <= w_is_div ? w_mag_b : w_mag_a;
        end
        MDU_ST_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op[2]) begin
            r_hi <= w_div_rem;
            r_lo <= {r_lo[XLEN-2:0], w_q_bit};
          end else begin
            r_hi <= w_mul_sum[XLEN:1];
            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
          end
        end
        MDU_ST_FIN: r_result <= r_special ? r_spec_val : w_final;
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign busy   = (r_state != MDU_ST_IDLE);
  assign done   = (r_state == MDU_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mul_div_unit : directed self-checking bench for mul_div_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA, srcB;
  logic [31:0] result;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int SPEC_LAT = 1;

  mul_div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .srcA   (srcA),
    .srcB   (srcB),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request, wait for done, check result, latency and busy.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " result"}, result, exp);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy"}, {31'd0, busy_ok & busy}, 32'd1);
    @(posedge clk); #1;
    check({tag, " idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; start = 1'b0; op = '0; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op("MUL 7*-3",      3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("MULHU -1*-1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("MULH -1*-1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    run_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_op("MULH big",      3'd1, 32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, MUL_LAT);
    run_op("DIV -7/2",      3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT);
    run_op("REM -7/2",      3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT);
    run_op("DIVU 100/7",    3'd5, 32'd100,      32'd7,        32'd14,        DIV_LAT);
    run_op("REMU 100/7",    3'd7, 32'd100,      32'd7,        32'd2,         DIV_LAT);
    run_op("REM 7/-2",      3'd6, 32'd7,        32'hFFFF_FFFE, 32'd1,         DIV_LAT);
    run_op("DIVU 100/0",    3'd5, 32'd100,      32'd0,        32'hFFFF_FFFF, SPEC_LAT);
    run_op("REMU 100/0",    3'd7, 32'd100,      32'd0,        32'h0000_0064, SPEC_LAT);
    run_op("DIV ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
    run_op("REM ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT);

    // start held with changing operands while a DIV runs must be ignored
    @(negedge clk);
    start = 1'b1; op = 3'd4; srcA = 32'hFFFF_FFF9; srcB = 32'd2;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      op = 3'($urandom); srcA = $urandom; srcB = $urandom; start = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("busy-start result", result, 32'hFFFF_FFFD);
    check("busy-start latency", 32'(lat), 32'd33);
    @(negedge clk);
    op = 3'd5; srcA = 32'd100; srcB = 32'd7;
    @(posedge clk); #1;
    check("no accept in DONE", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("accept from IDLE", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("re-accept result", result, 32'd14);
    check("re-accept latency", 32'(lat), 32'd33);
    @(posedge clk); #1;

    // reset on the 10th CALC edge aborts without a done pulse
    @(negedge clk);
    start = 1'b1; op = 3'd5; srcA = 32'd1000; srcB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("abort no done", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
